serial_paralelo_multilane: RTL



---
 rtl/phy_rx_pkg.sv | 17 +
 rtl/sp_lane.sv | 107 ++++++++++
 rtl/serial_paralelo_multilane.sv | 50 +++++
 3 files changed

// File: rtl/phy_rx_pkg.sv
// Shared types and constants for the PHY RX serial-to-parallel path.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_t;

    localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;

    // Register width able to hold 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sp_lane.sv
// One receive lane: bit-sliding COM search, symbol alignment, and
// registered parallel output with a one-cycle valid pulse per data symbol.
module sp_lane
    import phy_rx_pkg::*;
#(
    parameter int              BITS      = 8,
    parameter logic [BITS-1:0] COM_SYM   = BITS'(COM_SYM_DEFAULT),
    parameter int              COM_COUNT = 4
) (
    input  logic            clk_32f,
    input  logic            reset,
    input  logic            lane_en,
    input  logic            data_in,
    output logic [BITS-1:0] data_out,
    output logic            valid_out,
    output logic [1:0]      state_dbg,
    output logic [1:0]      state_nxt_dbg
);

    localparam int              BW       = cnt_width(BITS);
    localparam int              CW       = cnt_width(COM_COUNT + 1);
    localparam logic [BW-1:0]   LAST_BIT = BW'(BITS - 1);
    localparam logic [CW-1:0]   COM_MAX  = CW'(COM_COUNT);

    lane_state_t     state, state_nxt;
    logic [BITS-2:0] sr;
    logic [BITS-1:0] cand;
    logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [CW-1:0]   com_cnt, com_cnt_nxt;
    logic [BITS-1:0] data_nxt;
    logic            valid_nxt;
    logic            clr, boundary, is_com;

    // A disabled lane behaves exactly as if it were held in reset.
    assign clr      = reset || !lane_en;
    assign cand     = {sr, data_in};
    assign is_com   = (cand == COM_SYM);
    assign boundary = (bit_cnt == LAST_BIT);

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        com_cnt_nxt = com_cnt;
        data_nxt    = data_out;
        valid_nxt   = 1'b0;
        if (clr) begin
            state_nxt   = SEARCH;
            bit_cnt_nxt = '0;
            com_cnt_nxt = '0;
            data_nxt    = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (is_com) begin
                        bit_cnt_nxt = '0;
                        com_cnt_nxt = CW'(1);
                        state_nxt   = (COM_COUNT == 1) ? ACTIVE : ALIGN;
                    end
                end
                ALIGN: begin
                    bit_cnt_nxt = boundary ? '0 : bit_cnt + 1'b1;
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt_nxt = (com_cnt == COM_MAX) ? com_cnt : com_cnt + 1'b1;
                            if (com_cnt_nxt == COM_MAX) state_nxt = ACTIVE;
                        end else begin
                            // Alignment was false; slide again from the next bit.
                            state_nxt   = SEARCH;
                            com_cnt_nxt = '0;
                            bit_cnt_nxt = '0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt_nxt = boundary ? '0 : bit_cnt + 1'b1;
                    if (boundary && !is_com) begin
                        data_nxt  = cand;
                        valid_nxt = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_32f) begin
        if (clr) begin
            state     <= SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= cand[BITS-2:0];
            bit_cnt   <= bit_cnt_nxt;
            com_cnt   <= com_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
        end
    end

    assign state_dbg     = state;
    assign state_nxt_dbg = state_nxt;

endmodule

// File: rtl/serial_paralelo_multilane.sv
// N-lane serial-to-parallel receiver; lanes align independently on COM.
module serial_paralelo_multilane
    import phy_rx_pkg::*;
#(
    parameter int              LANES     = 2,
    parameter int              BITS      = 8,
    parameter logic [BITS-1:0] COM_SYM   = BITS'(COM_SYM_DEFAULT),
    parameter int              COM_COUNT = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    input  logic [LANES-1:0]      lane_en,
    input  logic [LANES-1:0]      data_in_SP,
    output logic [LANES*BITS-1:0] data_out,
    output logic [LANES-1:0]      valid_out,
    output logic [LANES-1:0]      active,
    output logic                  all_active
);

    logic [LANES-1:0] active_nxt;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [1:0] st, st_nxt;

        sp_lane #(
            .BITS      (BITS),
            .COM_SYM   (COM_SYM),
            .COM_COUNT (COM_COUNT)
        ) u_lane (
            .clk_32f       (clk_32f),
            .reset         (reset),
            .lane_en       (lane_en[l]),
            .data_in       (data_in_SP[l]),
            .data_out      (data_out[l*BITS +: BITS]),
            .valid_out     (valid_out[l]),
            .state_dbg     (st),
            .state_nxt_dbg (st_nxt)
        );

        assign active[l]     = (st == ACTIVE);
        assign active_nxt[l] = (st_nxt == ACTIVE);
    end

    // Built from next-state so it moves on the same edge as the last lane.
    always_ff @(posedge clk_32f) begin
        if (reset) all_active <= 1'b0;
        else       all_active <= &active_nxt;
    end

endmodule
